// File: rtl/dqn_step_sequencer.sv
// Step/phase sequencer for the DQN training datapath: runs MAX_STEP steps of FWD/BWD/UPD phases.
// Optional macro SEQ_PAUSE_EN enables the pause input; otherwise pause is ignored.
module dqn_step_sequencer #(
    parameter int unsigned MAX_STEP   = 15,
    parameter int unsigned FWD_CYCLES = 1,
    parameter int unsigned BWD_CYCLES = 1,
    parameter int unsigned UPD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       pause,
    output logic [3:0] step,
    output logic [3:0] controller,
    output logic       latch_pulse,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, FWD, BWD, UPD, DONE} state_t;

    localparam logic [7:0] FWD_LAST = 8'(FWD_CYCLES - 1);
    localparam logic [7:0] BWD_LAST = 8'(BWD_CYCLES - 1);
    localparam logic [7:0] UPD_LAST = 8'(UPD_CYCLES - 1);
    localparam logic [3:0] STEP_MAX = 4'(MAX_STEP);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [3:0] step_n;
    logic [3:0] controller_n;
    logic       latch_n, busy_n, done_n;
    logic       hold;

`ifdef SEQ_PAUSE_EN
    assign hold = pause && (state == FWD || state == BWD || state == UPD);
`else
    logic pause_unused;
    assign pause_unused = pause;
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            step        <= '0;
            cnt         <= '0;
            controller  <= '0;
            latch_pulse <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            step        <= step_n;
            cnt         <= cnt_n;
            controller  <= controller_n;
            latch_pulse <= latch_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        step_n  = step;
        cnt_n   = cnt;
        if (abort) begin
            state_n = IDLE;
            step_n  = '0;
            cnt_n   = '0;
        end else if (!hold) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n = FWD;
                        step_n  = 4'd1;
                        cnt_n   = '0;
                    end
                end
                FWD: begin
                    if (cnt == FWD_LAST) begin
                        state_n = BWD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                BWD: begin
                    if (cnt == BWD_LAST) begin
                        state_n = UPD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                UPD: begin
                    if (cnt == UPD_LAST) begin
                        cnt_n = '0;
                        if (step == STEP_MAX) begin
                            state_n = DONE;
                        end else begin
                            state_n = FWD;
                            step_n  = step + 4'd1;
                        end
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                DONE: begin
                    state_n = IDLE;
                    step_n  = '0;
                    cnt_n   = '0;
                end
                default: begin
                    state_n = IDLE;
                    step_n  = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        controller_n = '0;
        busy_n       = 1'b0;
        done_n       = 1'b0;
        latch_n      = (state_n == FWD) && (state != FWD);
        case (state_n)
            FWD:     begin controller_n = 4'd1; busy_n = 1'b1; end
            BWD:     begin controller_n = 4'd2; busy_n = 1'b1; end
            UPD:     begin controller_n = 4'd3; busy_n = 1'b1; end
            DONE:    done_n = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dqn_step_sequencer.sv
// Self-checking bench for dqn_step_sequencer: three parameter sets driven by shared inputs,
// each checked against an episode-list reference model.
module tb_dqn_step_sequencer;

`ifdef SEQ_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] step;
        logic [3:0] ctrl;
        logic       latch;
        logic       busy;
        logic       done;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start = 1'b0, abort = 1'b0, pause = 1'b0;
    logic [3:0] step_o [3];
    logic [3:0] ctrl_o [3];
    logic       latch_o[3];
    logic       busy_o [3];
    logic       done_o [3];

    int n_checks = 0;
    int n_fail   = 0;

    dqn_step_sequencer #(.MAX_STEP(3), .FWD_CYCLES(1), .BWD_CYCLES(1), .UPD_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
        .step(step_o[0]), .controller(ctrl_o[0]), .latch_pulse(latch_o[0]),
        .busy(busy_o[0]), .done(done_o[0]));

    dqn_step_sequencer #(.MAX_STEP(1), .FWD_CYCLES(2), .BWD_CYCLES(3), .UPD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
        .step(step_o[1]), .controller(ctrl_o[1]), .latch_pulse(latch_o[1]),
        .busy(busy_o[1]), .done(done_o[1]));

    dqn_step_sequencer #(.MAX_STEP(5), .FWD_CYCLES(1), .BWD_CYCLES(2), .UPD_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
        .step(step_o[2]), .controller(ctrl_o[2]), .latch_pulse(latch_o[2]),
        .busy(busy_o[2]), .done(done_o[2]));

    // Reference model: the whole episode as a list of per-cycle outputs, walked by a position.
    obs_t ep[$];
    int   pos;
    int   cfg_max, cfg_f, cfg_b, cfg_u;

    task automatic model_cfg(input int k);
        case (k)
            0:       begin cfg_max = 3; cfg_f = 1; cfg_b = 1; cfg_u = 1; end
            1:       begin cfg_max = 1; cfg_f = 2; cfg_b = 3; cfg_u = 1; end
            default: begin cfg_max = 5; cfg_f = 1; cfg_b = 2; cfg_u = 1; end
        endcase
        ep.delete();
        for (int s = 1; s <= cfg_max; s++) begin
            for (int i = 0; i < cfg_f; i++) ep.push_back('{4'(s), 4'd1, (i == 0), 1'b1, 1'b0});
            for (int i = 0; i < cfg_b; i++) ep.push_back('{4'(s), 4'd2, 1'b0, 1'b1, 1'b0});
            for (int i = 0; i < cfg_u; i++) ep.push_back('{4'(s), 4'd3, 1'b0, 1'b1, 1'b0});
        end
        ep.push_back('{4'(cfg_max), 4'd0, 1'b0, 1'b0, 1'b1});
        pos = -1;
    endtask

    function automatic obs_t model_next(input logic r, input logic st, input logic ab, input logic pa);
        obs_t e;
        logic held = 1'b0;
        if (r || ab) pos = -1;
        else if (pos < 0) begin
            if (st) pos = 0;
        end else if (PAUSE_EN && pa && ep[pos].busy) held = 1'b1;
        else begin
            pos++;
            if (pos >= ep.size()) pos = -1;
        end
        if (pos < 0) e = '0;
        else begin
            e = ep[pos];
            if (held) e.latch = 1'b0;
        end
        return e;
    endfunction

    function automatic obs_t get_obs(input int k);
        return '{step_o[k], ctrl_o[k], latch_o[k], busy_o[k], done_o[k]};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("step=%0d ctrl=%0d latch=%b busy=%b done=%b", o.step, o.ctrl, o.latch, o.busy, o.done);
    endfunction

    task automatic cycle(input logic r, input logic st, input logic ab, input logic pa, output obs_t e);
        rst = r; start = st; abort = ab; pause = pa;
        @(posedge clk);
        e = model_next(r, st, ab, pa);
        #1;
    endtask

    task automatic test_reset();
        obs_t e;
        model_cfg(0);
        for (int i = 0; i < 7; i++) begin
            cycle(i < 2, 1'b0, 1'b0, 1'b0, e);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (get_obs(k) !== e) begin
                    n_fail++;
                    $display("FAIL reset dut%0d cyc%0d: got %s, want %s", k, i, fmt(get_obs(k)), fmt(e));
                end
            end
        end
    endtask

    task automatic test_basic();
        obs_t e;
        int done_cyc = -1, latches = 0;
        model_cfg(0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, e);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, e);
        for (int i = 1; i <= 12; i++) begin
            if (get_obs(0).done && done_cyc < 0) done_cyc = i;
            if (get_obs(0).latch) latches++;
            n_checks++;
            if (get_obs(0) !== e) begin
                n_fail++;
                $display("FAIL basic cyc%0d: got %s, want %s", i, fmt(get_obs(0)), fmt(e));
            end
            cycle(1'b0, 1'b0, 1'b0, 1'b0, e);
        end
        n_checks++;
        if (done_cyc !== 10) begin
            n_fail++;
            $display("FAIL basic_done_cycle: got %0d, want 10", done_cyc);
        end
        n_checks++;
        if (latches !== 3) begin
            n_fail++;
            $display("FAIL basic_latch_count: got %0d, want 3", latches);
        end
    endtask

    task automatic test_stretched();
        obs_t e;
        int done_cyc = -1, latches = 0;
        model_cfg(1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, e);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, e);
        for (int i = 1; i <= 9; i++) begin
            if (get_obs(1).done && done_cyc < 0) done_cyc = i;
            if (get_obs(1).latch) latches++;
            n_checks++;
            if (get_obs(1) !== e) begin
                n_fail++;
                $display("FAIL stretched cyc%0d: got %s, want %s", i, fmt(get_obs(1)), fmt(e));
            end
            cycle(1'b0, 1'b0, 1'b0, 1'b0, e);
        end
        n_checks++;
        if (done_cyc !== 7 || latches !== 1) begin
            n_fail++;
            $display("FAIL stretched_shape: got done_cyc=%0d latches=%0d, want 7 and 1", done_cyc, latches);
        end
    endtask

    task automatic test_abort();
        obs_t e;
        logic aborted = 1'b0, ab;
        int dones = 0;
        model_cfg(2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, e);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, e);
        for (int i = 0; i < 20; i++) begin
            ab = !aborted && e.step == 2 && e.ctrl == 2;
            if (ab) aborted = 1'b1;
            cycle(1'b0, 1'b0, ab, 1'b0, e);
            if (done_o[2]) dones++;
            n_checks++;
            if (get_obs(2) !== e) begin
                n_fail++;
                $display("FAIL abort cyc%0d: got %s, want %s", i, fmt(get_obs(2)), fmt(e));
            end
        end
        n_checks++;
        if (!aborted || dones != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got aborted=%b dones=%0d, want 1 and 0", aborted, dones);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, e);
        for (int i = 0; i < 24; i++) begin
            n_checks++;
            if (get_obs(2) !== e) begin
                n_fail++;
                $display("FAIL restart cyc%0d: got %s, want %s", i, fmt(get_obs(2)), fmt(e));
            end
            cycle(1'b0, 1'b0, 1'b0, 1'b0, e);
        end
    endtask

    task automatic test_start_and_reset_mid_run();
        obs_t e;
        logic did_rst = 1'b0, r;
        model_cfg(2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, e);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, e);
        for (int i = 0; i < 20; i++) begin
            r = !did_rst && e.step == 3;
            if (r) did_rst = 1'b1;
            cycle(r, e.step == 2, 1'b0, 1'b0, e);
            n_checks++;
            if (get_obs(2) !== e) begin
                n_fail++;
                $display("FAIL midrun cyc%0d: got %s, want %s", i, fmt(get_obs(2)), fmt(e));
            end
        end
    endtask

    task automatic test_pause();
        obs_t e;
        int pleft = -1, busy_cnt = 0, want;
        logic seen_done = 1'b0;
        model_cfg(2);
        want = 5 * (1 + 2 + 1) + (PAUSE_EN ? 4 : 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, e);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, e);
        for (int i = 0; i < 60 && !seen_done; i++) begin
            if (busy_o[2]) busy_cnt++;
            if (done_o[2]) seen_done = 1'b1;
            n_checks++;
            if (get_obs(2) !== e) begin
                n_fail++;
                $display("FAIL pause cyc%0d: got %s, want %s", i, fmt(get_obs(2)), fmt(e));
            end
            if (pleft < 0 && e.step == 2 && e.ctrl == 2) pleft = 4;
            cycle(1'b0, 1'b0, 1'b0, pleft > 0, e);
            if (pleft > 0) pleft--;
        end
        n_checks++;
        if (!seen_done || busy_cnt != want) begin
            n_fail++;
            $display("FAIL pause_length: got done=%b busy_cycles=%0d, want 1 and %0d", seen_done, busy_cnt, want);
        end
    endtask

    task automatic test_random();
        obs_t e;
        for (int k = 0; k < 3; k++) begin
            model_cfg(k);
            cycle(1'b1, 1'b0, 1'b0, 1'b0, e);
            for (int i = 0; i < 400; i++) begin
                cycle($urandom % 150 == 0, $urandom % 4 == 0, $urandom % 40 == 0, $urandom % 5 == 0, e);
                n_checks++;
                if (get_obs(k) !== e) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc%0d: got %s, want %s", k, i, fmt(get_obs(k)), fmt(e));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stretched();
        test_abort();
        test_start_and_reset_mid_run();
        test_pause();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dqn_step_sequencer.md
Name: dqn_step_sequencer

Overview:
Generates the `step`/`controller` phase sequence consumed by the activation hold registers and the forward/back-prop datapath. Each training step runs three phases in order: controller=1 (forward / latch), 2 (back-prop), 3 (weight update). Steps count from 1 up to MAX_STEP; step=0 means idle, which freezes all downstream hold registers. The block sits between the top-level training control and the datapath.

Parameters:
MAX_STEP, 15, last step index of an episode; legal range 1..15.
FWD_CYCLES, 1, cycles spent in phase 1; legal range 1..255.
BWD_CYCLES, 1, cycles spent in phase 2; legal range 1..255.
UPD_CYCLES, 1, cycles spent in phase 3; legal range 1..255.

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
start  input  1  begin episode; sampled only in IDLE
abort  input  1  synchronous abort; returns to IDLE
pause  input  1  freeze sequence (only with SEQ_PAUSE_EN; otherwise ignored)
step  output  4  current step index, 0 when idle
controller  output  4  phase code: 0 idle, 1 fwd, 2 bwd, 3 upd
latch_pulse  output  1  high on the first cycle of each phase-1 window
busy  output  1  high in FWD/BWD/UPD
done  output  1  one-cycle pulse at episode end

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- All outputs are registered. Reset (rst=1 at posedge) forces state=IDLE, step=0, controller=0, latch_pulse=0, busy=0, done=0, phase counter=0.
- rst has priority over abort; abort has priority over pause and over normal advance.
- FSM states: IDLE, FWD, BWD, UPD, DONE.
- IDLE: step=0, controller=0. If start=1 at edge N, then after edge N: state=FWD, step=1, controller=1, latch_pulse=1, busy=1. A start asserted in any other state is ignored.
- FWD/BWD/UPD each hold for their parameter's number of cycles, counted by an 8-bit phase counter that clears on every phase entry.
  - FWD exits to BWD (controller=2); BWD exits to UPD (controller=3).
  - UPD exit: if step<MAX_STEP, go to FWD with step+1 and latch_pulse=1; if step==MAX_STEP, go to DONE.
- latch_pulse is high only on the first FWD cycle of each step, including when FWD_CYCLES>1.
- DONE: lasts exactly one cycle. done=1, busy=0, controller=0, step holds MAX_STEP. Next state is IDLE with step=0. start during DONE is ignored.
- With all *_CYCLES=1, one step takes 3 cycles and a full episode is 3*MAX_STEP cycles of busy=1, followed by 1 DONE cycle.
- abort=1 in any state: next cycle is IDLE with step=0, controller=0, busy=0, latch_pulse=0, and no done pulse.
- step never wraps; the 4-bit step saturates at MAX_STEP by construction.
- Mid-episode reset behaves identically to reset from IDLE.

Optional Feature:
Macro SEQ_PAUSE_EN.
- Defined: pause=1 in FWD, BWD or UPD freezes state, step, controller and the phase counter. latch_pulse is forced to 0 while paused and is not re-issued on resume; busy stays 1. When pause is released, the sequence continues from the frozen point, and the remaining phase cycles still elapse. pause has no effect in IDLE or DONE.
- Undefined: the pause port exists but is ignored, and the sequence never stalls.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then start=0 for 5 cycles -> step=0, controller=0, busy=0, done=0 throughout.
- Basic episode, MAX_STEP=3, all *_CYCLES=1: start pulse -> controller 1,2,3,1,2,3,1,2,3 with step 1,1,1,2,2,2,3,3,3; latch_pulse high on cycles 1, 4 and 7; done=1 on cycle 10; step=0 on cycle 11.
- Stretched phases, FWD_CYCLES=2, BWD_CYCLES=3, UPD_CYCLES=1, MAX_STEP=1: start -> controller 1,1,2,2,2,3; latch_pulse only on the first cycle; then done.
- Abort: MAX_STEP=5, abort=1 while step=2, controller=2 -> next cycle step=0, controller=0, busy=0, and done never pulses. A subsequent start restarts at step=1.
- Ignored start and reset mid-run: start re-pulsed while step=2 -> sequence unchanged. rst=1 while step=3 -> next cycle all outputs at reset values.
- SEQ_PAUSE_EN: pause=1 for 4 cycles during BWD of step 2 -> step=2 and controller=2 are held for those 4 cycles, latch_pulse=0, and the episode length grows by exactly 4 cycles. Without the macro, the same stimulus produces the nominal timing.
